calc_sequencer: RTL and testbench
=================================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 SHALL have port: Clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: Rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: InValid  input  1  upstream instruction valid.
REQ-004 SHALL have port: InReady  output  1  sequencer can accept an instruction this cycle.
REQ-005 SHALL have port: Instr  input  24  [23:20] Ctrl, [19] Sel, [18] WEN, [17:15] RW, [14:12] RX, [11:9] RY, [8] reserved, [7:0] immediate.
REQ-006 SHALL have ports: WEN 1, RW 3, RX 3, RY 3, DataIn 8, Sel 1, Ctrl 4, all outputs and registered; they drive the downstream calculator.
REQ-007 SHALL have port: Busy  output  1  FIFO non-empty or stall pending.
REQ-008 SHALL have port: IssueCnt  output  8  count of instructions issued.

Function
REQ-009 SHALL buffer instructions in a 4-entry FIFO; InReady = FIFO not full; a transfer occurs when InValid and InReady are both 1 at a rising edge.
REQ-010 SHALL accept a push and a pop in the same cycle when full; occupancy is unchanged and InReady stays 0.
REQ-011 SHALL use FSM states IDLE (FIFO empty), ISSUE (head popped and driven), STALL (one bubble inserted).
REQ-012 SHALL issue the head entry as follows: register its fields onto the outputs at the edge it is popped; DataIn = Instr[7:0]; minimum latency from accepted instruction to outputs valid is 1 cycle when FIFO empty.
REQ-013 SHALL issue at most one instruction per cycle, in FIFO order.
REQ-014 SHALL drive WEN=0 on the outputs in any cycle where nothing is issued (IDLE or STALL); other outputs hold previous values.
REQ-015 SHALL detect a hazard when the head reads register r while the instruction currently on the outputs has WEN=1 and RW=r. The head reads r if its RY=r, or if its Sel=1 and RX=r.
REQ-016 SHALL on hazard enter STALL for exactly one cycle (WEN=0), then issue the head.
REQ-017 SHALL ignore Instr[8].
REQ-018 SHALL increment IssueCnt by 1 per issued instruction, wrapping 255->0; bubbles are not counted.
REQ-019 SHALL set Busy = FIFO non-empty OR state==STALL.
REQ-020 SHALL transition IDLE->ISSUE when FIFO non-empty, ISSUE->IDLE when FIFO empty after pop, ISSUE->STALL on hazard, STALL->ISSUE unconditionally.

Reset
REQ-021 SHALL on Rst=1 immediately (asynchronously) clear the FIFO and pointers, set state IDLE, IssueCnt=0, WEN=0, RW=RX=RY=0, DataIn=0, Sel=0, Ctrl=0.
REQ-022 SHALL drive InReady=0 while Rst=1, and InReady=1 in the first cycle after release.
REQ-023 SHALL discard in-flight and buffered instructions when Rst asserts mid-operation; no partial write is issued after release.

Configuration
REQ-024 SHALL, with macro CALC_SEQ_HAZARD_EN defined, implement the hazard detection and STALL state of REQ-015/016.
REQ-025 SHALL, without CALC_SEQ_HAZARD_EN, never enter STALL and issue back-to-back regardless of register overlap.

Verification
REQ-026 SHALL cover single issue: empty FIFO, push Instr=0x4_1_1_00_A5 style {Ctrl=4, Sel=0, WEN=1, RW=2, imm=0xA5} -> next edge WEN=1, RW=2, DataIn=0xA5, Ctrl=4, IssueCnt=1.
REQ-027 SHALL cover full FIFO: hold InValid=1 with the pipeline blocked by hazards -> InReady=0 after the 4th buffered entry; no entry is lost or duplicated.
REQ-028 SHALL cover hazard: issue {WEN=1, RW=3}, then {Sel=1, RX=3} -> one WEN=0 bubble, then issue; IssueCnt +2 over 3 cycles (macro defined); 2 cycles with no bubble (macro undefined).
REQ-029 SHALL cover no false hazard: {WEN=1, RW=3}, then {Sel=0, RX=3, RY=1} -> no stall.
REQ-030 SHALL cover wrap and reset: issue 256 instructions -> IssueCnt=0; assert Rst mid-stream -> all outputs 0 and Busy=0 immediately.

Source files
------------

// File: rtl/calc_sequencer.sv
// Instruction sequencer: a 4-entry FIFO feeding a registered issue stage for a downstream calculator.
// Define CALC_SEQ_HAZARD_EN to add one-cycle read-after-write stalls; without it, issue is back-to-back.
module calc_sequencer (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        InValid,
  output logic        InReady,
  input  logic [23:0] Instr,
  output logic        WEN,
  output logic [2:0]  RW,
  output logic [2:0]  RX,
  output logic [2:0]  RY,
  output logic [7:0]  DataIn,
  output logic        Sel,
  output logic [3:0]  Ctrl,
  output logic        Busy,
  output logic [7:0]  IssueCnt
);

  typedef struct packed {
    logic [3:0] ctrl;
    logic       sel;
    logic       wen;
    logic [2:0] rw;
    logic [2:0] rx;
    logic [2:0] ry;
    logic [7:0] imm;
  } entry_t;

  typedef enum logic [1:0] {StIdle, StIssue, StStall} state_e;

  state_e     state_q;
  entry_t     mem_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q;

  entry_t in_entry, head;
  logic   full, empty, hazard, pop, push;
  logic   unused_rsvd;

  // Instr[8] is reserved and deliberately dropped.
  assign unused_rsvd = Instr[8];
  assign in_entry    = '{ctrl: Instr[23:20], sel: Instr[19], wen: Instr[18], rw: Instr[17:15],
                         rx: Instr[14:12], ry: Instr[11:9], imm: Instr[7:0]};
  assign head        = mem_q[rd_ptr_q];

  assign full  = (count_q == 3'd4);
  assign empty = (count_q == 3'd0);

`ifdef CALC_SEQ_HAZARD_EN
  // Head reads RY always, and RX only when Sel selects the register operand.
  assign hazard = (state_q == StIssue) && WEN &&
                  ((head.ry == RW) || (head.sel && (head.rx == RW)));
`else
  assign hazard = 1'b0;
`endif

  assign pop  = !empty && !hazard;
  // A full FIFO still takes a new entry in a cycle where the head leaves.
  assign push = InValid && (!full || pop);

  assign InReady = !full && !Rst;
  assign Busy    = !empty || (state_q == StStall);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      state_q  <= StIdle;
      WEN      <= 1'b0;
      RW       <= 3'd0;
      RX       <= 3'd0;
      RY       <= 3'd0;
      DataIn   <= 8'd0;
      Sel      <= 1'b0;
      Ctrl     <= 4'd0;
      IssueCnt <= 8'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_entry;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;

      unique case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase

      if (pop) begin
        state_q  <= StIssue;
        WEN      <= head.wen;
        RW       <= head.rw;
        RX       <= head.rx;
        RY       <= head.ry;
        DataIn   <= head.imm;
        Sel      <= head.sel;
        Ctrl     <= head.ctrl;
        IssueCnt <= IssueCnt + 8'd1;
      end else begin
        // Nothing leaves: either a bubble for a hazard or the FIFO is empty.
        WEN     <= 1'b0;
        state_q <= hazard ? StStall : StIdle;
      end
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: accepted instructions are queued and matched on each issue.
module tb_calc_sequencer;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        InValid = 1'b0;
  logic [23:0] Instr = '0;
  logic        InReady, WEN, Sel, Busy;
  logic [2:0]  RW, RX, RY;
  logic [7:0]  DataIn, IssueCnt;
  logic [3:0]  Ctrl;

  calc_sequencer dut (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady), .Instr(Instr),
    .WEN(WEN), .RW(RW), .RX(RX), .RY(RY), .DataIn(DataIn), .Sel(Sel), .Ctrl(Ctrl),
    .Busy(Busy), .IssueCnt(IssueCnt)
  );

  always #5 Clk = ~Clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [23:0] sb[$];
  logic [7:0]  mon_cnt = 8'd0;
  logic [7:0]  npush = 8'd0;
  logic [7:0]  base;
  logic [23:0] mon_e;
  logic        saw_full = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] mk(input logic [3:0] ctrl, input logic sel, input logic wen,
                                     input logic [2:0] rw, input logic [2:0] rx,
                                     input logic [2:0] ry, input logic [7:0] imm);
    return {ctrl, sel, wen, rw, rx, ry, 1'b1, imm};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // InValid stays low while waiting so a full-FIFO cycle never takes a stale word.
  task automatic push(input logic [23:0] v);
    int guard = 0;
    while (!InReady && guard < 200) begin
      saw_full = 1'b1;
      tick();
      guard++;
    end
    check("push_ready", 32'(InReady), 32'd1);
    InValid = 1'b1;
    Instr   = v;
    tick();
    InValid = 1'b0;
    sb.push_back(v);
    npush = npush + 8'd1;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (Busy && guard < 1000) begin
      tick();
      guard++;
    end
    check("drain_busy", 32'(Busy), 32'd0);
    tick();
    tick();
    check("drain_cnt", 32'(IssueCnt), 32'(npush));
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, 32'({WEN, RW, RX, RY, DataIn, Sel, Ctrl, IssueCnt, Busy, InReady}), 32'd0);
  endtask

  // Issue monitor: a change of IssueCnt marks one issue; otherwise WEN must be low.
  always @(negedge Clk) begin
    if (!Rst) begin
      if (IssueCnt !== mon_cnt) begin
        mon_cnt = mon_cnt + 8'd1;
        check("issue_cnt_step", 32'(IssueCnt), 32'(mon_cnt));
        n_cmp++;
        assert (sb.size() != 0) else begin
          n_bad++;
          $error("FAIL unexpected_issue: observed issue with %0d queued expected none", sb.size());
        end
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("issue_fields", 32'({Ctrl, Sel, WEN, RW, RX, RY, DataIn}),
                32'({mon_e[23:9], mon_e[7:0]}));
        end
      end else begin
        check("bubble_wen", 32'(WEN), 32'd0);
      end
    end
  end

  initial begin
    #1;
    check_reset_outputs("reset_outputs");
    tick();
    tick();
    Rst = 1'b0;
    #1;
    check("ready_after_reset", 32'(InReady), 32'd1);

    // Single issue, one cycle after acceptance.
    push(mk(4'd4, 1'b0, 1'b1, 3'd2, 3'd0, 3'd0, 8'hA5));
    tick();
    check("single_wen", 32'(WEN), 32'd1);
    check("single_rw", 32'(RW), 32'd2);
    check("single_data", 32'(DataIn), 32'hA5);
    check("single_ctrl", 32'(Ctrl), 32'd4);
    check("single_cnt", 32'(IssueCnt), 32'd1);
    wait_idle();

    // Hazard through RX with Sel=1.
    base = npush;
    push(mk(4'd1, 1'b0, 1'b1, 3'd3, 3'd0, 3'd0, 8'h11));
    push(mk(4'd2, 1'b1, 1'b1, 3'd5, 3'd3, 3'd0, 8'h22));
    check("hz_first", 32'(IssueCnt), 32'(base + 8'd1));
    tick();
`ifdef CALC_SEQ_HAZARD_EN
    check("hz_bubble_wen", 32'(WEN), 32'd0);
    check("hz_bubble_busy", 32'(Busy), 32'd1);
    check("hz_bubble_cnt", 32'(IssueCnt), 32'(base + 8'd1));
    tick();
`endif
    check("hz_second_cnt", 32'(IssueCnt), 32'(base + 8'd2));
    check("hz_second_rx", 32'(RX), 32'd3);
    wait_idle();

    // RX matches RW but Sel=0, so no dependency.
    base = npush;
    push(mk(4'd3, 1'b0, 1'b1, 3'd3, 3'd0, 3'd0, 8'h33));
    push(mk(4'd5, 1'b0, 1'b1, 3'd6, 3'd3, 3'd1, 8'h44));
    check("nohz_first", 32'(IssueCnt), 32'(base + 8'd1));
    tick();
    check("nohz_second", 32'(IssueCnt), 32'(base + 8'd2));
    wait_idle();

    // Dependent chain: every instruction reads and writes r1.
    saw_full = 1'b0;
    for (int i = 0; i < 7; i++) push(mk(4'(i), 1'b0, 1'b1, 3'd1, 3'd0, 3'd1, 8'(8'h60 + i)));
`ifdef CALC_SEQ_HAZARD_EN
    check("full_ready", 32'(InReady), 32'd0);
    check("full_busy", 32'(Busy), 32'd1);
`else
    check("nofull_ready", 32'(InReady), 32'd1);
`endif
    for (int i = 7; i < 10; i++) push(mk(4'(i), 1'b0, 1'b1, 3'd1, 3'd0, 3'd1, 8'(8'h60 + i)));
`ifdef CALC_SEQ_HAZARD_EN
    check("full_seen", 32'(saw_full), 32'd1);
`else
    check("full_never", 32'(saw_full), 32'd0);
`endif
    wait_idle();

    // Reset mid-stream discards everything.
    for (int i = 0; i < 3; i++) push(mk(4'hF, 1'b1, 1'b1, 3'd2, 3'd2, 3'd2, 8'(8'hC0 + i)));
    Rst = 1'b1;
    #1;
    check_reset_outputs("midreset_outputs");
    sb.delete();
    mon_cnt = 8'd0;
    npush   = 8'd0;
    tick();
    tick();
    Rst = 1'b0;
    #1;
    check("midreset_ready", 32'(InReady), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    check("midreset_cnt", 32'(IssueCnt), 32'd0);
    check("midreset_wen", 32'(WEN), 32'd0);

    // 256 issues wrap the counter back to zero.
    for (int i = 0; i < 256; i++) push(24'($urandom));
    wait_idle();
    check("wrap_cnt", 32'(IssueCnt), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
